// File: rtl/calc_display_ctrl.sv
// Display back end for the calculator core: captures one serialized 8-digit
// frame into a shadow bank, commits it atomically, and scans eight common-anode digits.
module calc_display_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       commit,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_ERROR = 2'b00,
        ST_BUSY  = 2'b01,
        ST_READY = 2'b10,
        ST_PRINT = 2'b11
    } status_e;

    localparam int             DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_O     = 7'b0100011;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    logic [3:0]       r_shadow [8];
    logic [3:0]       r_disp   [8];
    logic [3:0]       w_shadow_next [8];
    logic [3:0]       r_pos_q;
    status_e          r_status_q;
    logic             r_commit;
    logic             r_busy;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_sel;
    logic [7:0]       r_an;
    logic [6:0]       r_seg;

    logic             w_cap;
    logic             w_commit;
    logic [3:0]       w_pos_m1;
    logic [7:0]       w_lead;
    logic [7:0]       w_digit_blank;
    logic [6:0]       w_seg_next;

    assign w_pos_m1 = pos - 4'd1;
    assign w_cap    = (status == ST_PRINT) && (pos != r_pos_q) &&
                      (pos >= 4'd1) && (pos <= 4'd8);
    assign w_commit = (r_status_q == ST_PRINT) && (status == ST_READY);

    // Fold a same-cycle capture into the bank that is about to be committed.
    always_comb begin
        for (int k = 0; k < 8; k++) w_shadow_next[k] = r_shadow[k];
        if (w_cap) w_shadow_next[w_pos_m1[2:0]] = data;
    end

    // NOTE: both digit banks are reset explicitly so a frame aborted by reset
    // can never leak into the next commit; they are small enough to be plain flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 8; k++) begin
                r_shadow[k] <= 4'd0;
                r_disp[k]   <= 4'd0;
            end
            r_pos_q    <= 4'd0;
            r_status_q <= ST_READY;
            r_commit   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_pos_q    <= pos;
            r_status_q <= status_e'(status);
            r_commit   <= w_commit;
            r_busy     <= (status == ST_BUSY);
            for (int k = 0; k < 8; k++) begin
                if (w_commit) begin
                    r_disp[k]   <= w_shadow_next[k];
                    r_shadow[k] <= 4'd0;
                end else begin
                    r_shadow[k] <= w_shadow_next[k];
                end
            end
        end
    end

    // A digit is a leading zero when it and everything above it carry no numeral.
    always_comb begin
        w_lead[7] = (r_disp[7] == 4'd0) || (r_disp[7] > 4'd9);
        for (int k = 6; k >= 0; k--)
            w_lead[k] = w_lead[k+1] && ((r_disp[k] == 4'd0) || (r_disp[k] > 4'd9));
        for (int k = 0; k < 8; k++)
            w_digit_blank[k] = (r_disp[k] > 4'd9) || (BLANK_ZEROS && (k != 0) && w_lead[k]);
    end

    always_comb begin
        w_seg_next = SEG_BLANK;
        if (status == ST_ERROR) begin
            case (r_sel)
                3'd3:      w_seg_next = SEG_E;
                3'd2:      w_seg_next = SEG_R;
                3'd1:      w_seg_next = SEG_R;
                3'd0:      w_seg_next = SEG_O;
                default:   w_seg_next = SEG_BLANK;
            endcase
        end else if (!w_digit_blank[r_sel]) begin
            w_seg_next = bcd_to_seg(r_disp[r_sel]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
            r_sel <= 3'd0;
            r_an  <= 8'hFF;
            r_seg <= SEG_BLANK;
        end else begin
            if (r_div == DIV_LAST) begin
                r_div <= '0;
                r_sel <= r_sel + 3'd1;
            end else begin
                r_div <= r_div + 1'b1;
            end
            r_an  <= ~(8'h01 << r_sel);
            r_seg <= w_seg_next;
        end
    end

    assign an     = r_an;
    assign seg    = r_seg;
    assign commit = r_commit;
    assign busy   = r_busy;

endmodule
